// File: rtl/uart_pkg.sv
// Shared UART definitions: frame width, default bit-time divisor and the
// receiver state encoding, common to both ends of the link.
package uart_pkg;

  localparam int DATA_BITS        = 8;
  localparam int BAUD_DIV_DEFAULT = 10;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage : uart_pkg

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input; the reset value
// should match the input's idle level so no false edge follows reset.
module sync_2ff #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: non-blocking assignments make meta->q a true two-stage shift;
  // blocking ones would collapse both flops into one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule : sync_2ff

// File: rtl/uart_rx.sv
// 8N1 UART receiver: start-edge detect, mid-bit sampling from a fixed
// divisor, one-deep holding register with full/rd handshake and error flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int BAUD_DIV = BAUD_DIV_DEFAULT
) (
  input  logic                 clk,
  input  logic                 resn,
  input  logic                 serialIn,
  input  logic                 rd,
  output logic [DATA_BITS-1:0] data,
  output logic                 full,
  output logic                 frameErr,
  output logic                 overrun
);

  localparam int CNT_W = $clog2(BAUD_DIV);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(BAUD_DIV / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(BAUD_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

  rx_state_t            state;
  logic [CNT_W-1:0]     baud_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DATA_BITS-1:0] shreg;
  logic                 rxs;
  logic                 rxp;
  logic [1:0]           warm;
  logic                 baud_done;

  sync_2ff #(.RESET_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (resn),
    .d   (serialIn),
    .q   (rxs)
  );

  assign baud_done = (baud_cnt == '0);

  // The synchroniser holds a fake idle level for two cycles after reset, so
  // rxp stays low until rxs reflects the real line; a line still low at
  // reset release therefore has to go high before a start edge can be seen.
  always_ff @(posedge clk or posedge resn) begin
    if (resn) begin
      warm <= '0;
      rxp  <= 1'b0;
    end else begin
      warm <= {warm[0], 1'b1};
      rxp  <= warm[1] & rxs;
    end
  end

  // NOTE: the shift register is reset along with the control state; it is
  // only eight flops and keeps the datapath free of X after reset.
  always_ff @(posedge clk or posedge resn) begin
    if (resn) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      data     <= '0;
      full     <= 1'b0;
      frameErr <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      frameErr <= 1'b0;
      if (rd) begin
        full    <= 1'b0;
        overrun <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (rxp && !rxs) begin
            baud_cnt <= HALF_LOAD;
            state    <= START;
          end
        end

        START: begin
          if (baud_done) begin
            if (rxs) begin
              state <= IDLE;
            end else begin
              baud_cnt <= BIT_LOAD;
              bit_cnt  <= '0;
              state    <= DATA;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end

        DATA: begin
          if (baud_done) begin
            shreg[bit_cnt] <= rxs;
            baud_cnt       <= BIT_LOAD;
            if (bit_cnt == LAST_BIT) state <= STOP;
            else                     bit_cnt <= bit_cnt + BIT_W'(1);
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end

        STOP: begin
          if (baud_done) begin
            state <= IDLE;
            // A good stop with rd in the same cycle overrides the rd clear.
            if (!rxs) begin
              frameErr <= 1'b1;
            end else if (!full || rd) begin
              data <= shreg;
              full <= 1'b1;
            end else begin
              overrun <= 1'b1;
            end
          end else begin
            baud_cnt <= baud_cnt - CNT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule : uart_rx

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a bit-banging transmitter pushes expected
// bytes to a scoreboard that is popped whenever the receiver presents data.
module tb_uart_rx;
  import uart_pkg::*;

  localparam int BD = 10;

  logic       clk = 1'b0;
  logic       resn = 1'b1;
  logic       serialIn = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       full;
  logic       frameErr;
  logic       overrun;

  uart_rx #(.BAUD_DIV(BD)) dut (
    .clk      (clk),
    .resn     (resn),
    .serialIn (serialIn),
    .rd       (rd),
    .data     (data),
    .full     (full),
    .frameErr (frameErr),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  logic [7:0] sb[$];

  always @(posedge clk) cyc++;

  // Monitor: counts frameErr pulses, their width, overrun cycles, full rises.
  int fe_cnt = 0, fe_run = 0, fe_last_w = 0, ov_cycles = 0, full_rise_cyc = 0;
  logic full_prev = 1'b0;
  always @(negedge clk) begin
    if (frameErr) begin
      if (fe_run == 0) fe_cnt++;
      fe_run++;
    end else if (fe_run > 0) begin
      fe_last_w = fe_run;
      fe_run    = 0;
    end
    if (overrun) ov_cycles++;
    if (full && !full_prev) full_rise_cyc = cyc;
    full_prev = full;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input bit push);
    logic [9:0] f;
    f = {stop, b, 1'b0};
    if (push) sb.push_back(b);
    for (int i = 0; i < 10; i++) begin
      serialIn = f[i];
      tick(BD);
    end
  endtask

  task automatic pulse_rd();
    @(posedge clk);
    #1 rd = 1'b1;
    @(posedge clk);
    #1 rd = 1'b0;
  endtask

  // Waits (bounded) for full, compares against the scoreboard, then reads.
  task automatic read_byte(input string tag);
    logic [7:0] exp;
    bit         got;
    got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      got = full;
    end
    check({tag, "_full_timeout"}, {31'b0, got}, 32'd1);
    if (got) begin
      if (sb.size() > 0) begin
        exp = sb.pop_front();
        check(tag, {24'b0, data}, {24'b0, exp});
      end else begin
        check({tag, "_unexpected"}, {24'b0, data}, 32'hFFFF_FFFF);
      end
      pulse_rd();
    end
  endtask

  int fe_base, ov_base, t_start, lat;
  logic [7:0] exp_b;

  initial begin
    // Reset state
    #2;
    check("rst_data", {24'b0, data}, 32'h0);
    check("rst_full", {31'b0, full}, 32'h0);
    check("rst_ferr", {31'b0, frameErr}, 32'h0);
    check("rst_ovr", {31'b0, overrun}, 32'h0);
    tick(3);
    resn = 1'b0;
    tick(5);

    // 1: back-to-back bytes 0x00..0x0A, read one cycle after each full
    fe_base = fe_cnt;
    ov_base = ov_cycles;
    t_start = cyc + 1;
    lat     = -1;
    fork
      begin
        for (int k = 0; k <= 10; k++) begin
          send_frame(8'(k), 1'b1, 1'b1);
          if (k == 0) lat = full_rise_cyc - t_start;
        end
      end
      begin
        for (int k = 0; k <= 10; k++) read_byte($sformatf("loop_%0d", k));
      end
    join
    check("latency_97_to_99", {31'b0, (lat >= 97 && lat <= 99)}, 32'd1);
    check("loop_ferr", fe_cnt - fe_base, 32'd0);
    check("loop_ovr", ov_cycles - ov_base, 32'd0);
    check("loop_sb_empty", sb.size(), 32'd0);
    tick(20);

    // 2: 3-cycle glitch is a false start
    fe_base  = fe_cnt;
    serialIn = 1'b0;
    tick(3);
    serialIn = 1'b1;
    tick(BD / 2 + 3 + 2);
    check("glitch_idle", 32'(dut.state), 32'(IDLE));
    check("glitch_full", {31'b0, full}, 32'h0);
    check("glitch_ferr", fe_cnt - fe_base, 32'd0);
    tick(20);

    // 3: 0x55 with a low stop bit, line left low, then released
    fe_base = fe_cnt;
    send_frame(8'h55, 1'b0, 1'b0);
    tick(20);
    serialIn = 1'b1;
    tick(150);
    check("ferr_pulses", fe_cnt - fe_base, 32'd1);
    check("ferr_width", fe_last_w, 32'd1);
    check("ferr_full", {31'b0, full}, 32'h0);

    // 4: overrun, 0x22 discarded while 0x11 is unread
    send_frame(8'h11, 1'b1, 1'b1);
    send_frame(8'h22, 1'b1, 1'b0);
    tick(5);
    @(negedge clk);
    exp_b = sb.pop_front();
    check("ovr_full", {31'b0, full}, 32'h1);
    check("ovr_data", {24'b0, data}, {24'b0, exp_b});
    check("ovr_flag", {31'b0, overrun}, 32'h1);
    pulse_rd();
    @(negedge clk);
    check("ovr_rd_full", {31'b0, full}, 32'h0);
    check("ovr_rd_flag", {31'b0, overrun}, 32'h0);
    tick(10);

    // 5: rd on the stop-sample cycle of 0x33 while 0x11 is held
    send_frame(8'h11, 1'b1, 1'b1);
    tick(5);
    @(negedge clk);
    exp_b = sb.pop_front();
    check("sim_hold", {24'b0, data}, {24'b0, exp_b});
    tick(0);
    ov_base = ov_cycles;
    fork
      send_frame(8'h33, 1'b1, 1'b1);
      begin
        repeat (97) @(posedge clk);
        #1 rd = 1'b1;
        @(posedge clk);
        #1 rd = 1'b0;
      end
    join
    @(negedge clk);
    exp_b = sb.pop_front();
    check("sim_data", {24'b0, data}, {24'b0, exp_b});
    check("sim_full", {31'b0, full}, 32'h1);
    check("sim_ovr", ov_cycles - ov_base, 32'd0);
    tick(5);

    // 6: reset during bit 4 of 0xA5 (a low bit), line held low past release
    begin
      logic [9:0] f;
      f = {1'b1, 8'hA5, 1'b0};
      for (int i = 0; i < 5; i++) begin
        serialIn = f[i];
        tick(BD);
      end
      serialIn = f[5];
    end
    tick(4);
    #2 resn = 1'b1;
    #1;
    check("mid_rst_full", {31'b0, full}, 32'h0);
    check("mid_rst_data", {24'b0, data}, 32'h0);
    check("mid_rst_ovr", {31'b0, overrun}, 32'h0);
    check("mid_rst_ferr", {31'b0, frameErr}, 32'h0);
    sb.delete();
    tick(2);
    resn    = 1'b0;
    fe_base = fe_cnt;
    tick(30);
    serialIn = 1'b1;
    tick(120);
    check("post_rst_full", {31'b0, full}, 32'h0);
    check("post_rst_ferr", fe_cnt - fe_base, 32'd0);
    fork
      send_frame(8'h5A, 1'b1, 1'b1);
      read_byte("post_rst_5a");
    join
    check("post_rst_ovr", {31'b0, overrun}, 32'h0);
    check("final_sb_empty", sb.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_uart_rx

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Receive end of the serial link driven by the `tx` block: 8N1, LSB first, idle-high line.
- Synchronises `serialIn`, detects the start bit, samples each bit at mid-bit using a fixed clock-cycle divisor, and presents the byte in a one-deep holding register.
- A `full`/`rd` handshake mirrors the transmitter's `wr`/`empty` pair.
- Framing and overrun errors are flagged to the consumer (CPU-side peripheral bus).

Parameters:
- `BAUD_DIV`, 10, clock cycles per bit time; must be ≥ 4; half-bit = `BAUD_DIV`/2 (integer floor).

Ports:
- `clk` · input · 1 · system clock, all logic on posedge.
- `resn` · input · 1 · reset, asynchronous, active-high.
- `serialIn` · input · 1 · asynchronous serial line, idle high.
- `rd` · input · 1 · consumer acknowledges the byte; one-cycle pulse.
- `data` · output · 8 · received byte, valid while `full`=1.
- `full` · output · 1 · holding register contains an unread byte.
- `frameErr` · output · 1 · one-cycle pulse: stop bit sampled low.
- `overrun` · output · 1 · sticky: a byte completed while `full`=1; cleared by `rd`.

Behaviour:
- Reset (async, active-high): state=IDLE, `data`=0x00, `full`=0, `frameErr`=0, `overrun`=0, bit counter=0, baud counter=0, synchroniser flops=1 (idle).
- Synchroniser: `serialIn` passes through 2 flops to give `rxs`. A previous-value flop `rxp` is used for edge detection. All FSM decisions use `rxs` only.
- IDLE:
  - Falling edge (`rxp`=1, `rxs`=0) loads baud counter = `BAUD_DIV`/2 − 1 and goes to START.
  - A line held low (break) never re-triggers; it must return high first.
- START:
  - Counter decrements to 0 (half-bit later), then sample `rxs`.
  - `rxs`=1: false start, go to IDLE, no flags.
  - `rxs`=0: load counter = `BAUD_DIV` − 1, bit counter=0, go to DATA.
- DATA:
  - On each counter expiry, shift `rxs` into bit[bitcnt] (LSB first) and reload `BAUD_DIV` − 1.
  - After bit 7, go to STOP.
- STOP, on counter expiry, sample `rxs`:
  - `rxs`=1, `full`=0 (or `rd` same cycle): load `data`, set `full`=1.
  - `rxs`=1, `full`=1 and no `rd`: byte discarded, `overrun`←1, `data` unchanged.
  - `rxs`=0: byte discarded, `frameErr`=1 for exactly one cycle, `full`/`data` unchanged.
  - All cases return to IDLE.
- `rd` handling:
  - `rd` with `full`=1 clears `full` and `overrun` next cycle.
  - `rd` with `full`=0 clears `overrun` only.
  - `rd` in the same cycle as a good stop sample: new byte loaded, `full` stays 1, `overrun` not set.
- Latency: `full` rises 2 (sync) + `BAUD_DIV`/2 + 9·`BAUD_DIV` + 1 cycles after the first clk edge at which `serialIn` is low (±1 tolerated by the bench).
- Back-to-back frames: a start edge may be accepted on the cycle after STOP returns to IDLE; no extra idle time is required.
- Reset mid-frame: immediate return to reset values; the partial byte is lost. A line still low after reset release is ignored until high.
- All outputs are registered; no combinational path from `serialIn` or `rd` to any output.

Decomposition:
- Shared package `uart_pkg`:
  - `DATA_BITS`=8.
  - State enum `rx_state_t` {IDLE, START, DATA, STOP}, also reused by any future tx rework.
  - Default `BAUD_DIV` constant shared with `tx` so both ends agree.
- One sub-module, `sync_2ff`: 2-flop synchroniser with reset value parameter (here 1), reusable for other async inputs.
- FSM, baud counter, shift register and holding register stay in `uart_rx`.

Test Plan:
1. Loopback: `tx.serialOut`→`uart_rx.serialIn`, `BAUD_DIV`=10; send 0x00..0x0A, `rd` one cycle after each `full` → each byte read equals the sent byte in order; `frameErr`=0 and `overrun`=0 throughout.
2. Glitch: drive `serialIn` low for 3 cycles from idle → no `full`, no `frameErr`; FSM back in IDLE within `BAUD_DIV`/2 + 3 cycles.
3. Framing: bit-banged frame 0x55 with stop bit=0 → `frameErr` single-cycle pulse at stop sample, `full`=0; line left low 30 cycles then released → no spurious frame.
4. Overrun: send 0x11 then 0x22 with no `rd` → `full`=1, `data`=0x11, `overrun`=1; then `rd` → `full`=0 and `overrun`=0 next cycle.
5. Simultaneous: `rd` asserted exactly on the stop-sample cycle of 0x33 while holding 0x11 → `data`=0x33, `full`=1, `overrun`=0.
6. Reset mid-frame: assert `resn` during bit 4 of 0xA5 → outputs return to reset values asynchronously; next clean 0x5A is received correctly.
